// File: rtl/jpeg_rle_encoder.sv
// JPEG run-length symbol generator: zigzag coefficients in, (run, size, amp) symbols out.
// Define JPEG_RLE_DC_DIFF_EN to enable DC differential prediction and pred_clr.
module jpeg_rle_encoder (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [11:0] in_coef,
  input  logic        pred_clr,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [3:0]  out_run,
  output logic [3:0]  out_size,
  output logic [11:0] out_amp,
  output logic        out_dc,
  output logic        out_eob
);

  localparam int unsigned CW = 12;
  localparam int unsigned DW = 13;
  localparam int unsigned IW = 6;
  localparam int unsigned SW = 4;

  typedef enum logic [1:0] {
    S_ACCEPT = 2'd0,
    S_ZRL    = 2'd1,
    S_HOLD   = 2'd2
  } state_t;

  typedef struct packed {
    logic [SW-1:0] run;
    logic [SW-1:0] size;
    logic [CW-1:0] amp;
    logic          dc;
    logic          eob;
  } sym_t;

  // Magnitude category: bit length of |x| for a 13-bit two's complement value.
  function automatic logic [SW-1:0] f_cat(input logic [DW-1:0] x);
    logic [DW-1:0] mag;
    logic [SW-1:0] c;
    mag = x[DW-1] ? DW'(-x) : x;
    c   = '0;
    for (int unsigned i = 0; i < DW; i++) begin
      if (mag[i]) c = SW'(i + 1);
    end
    return c;
  endfunction

  function automatic logic [CW-1:0] f_amp(input logic [DW-1:0] x, input logic [SW-1:0] sz);
    logic [DW-1:0] v;
    logic [DW-1:0] mask;
    v    = x[DW-1] ? (x - DW'(1)) : x;
    mask = (DW'(1) << sz) - DW'(1);
    return CW'(v & mask);
  endfunction

  function automatic sym_t f_sym(input logic [SW-1:0] run, input logic [SW-1:0] size,
                                 input logic [CW-1:0] amp, input logic dc, input logic eob);
    sym_t s;
    s.run  = run;
    s.size = size;
    s.amp  = amp;
    s.dc   = dc;
    s.eob  = eob;
    return s;
  endfunction

  state_t        r_state;
  logic [IW-1:0] r_idx;
  logic [IW-1:0] r_run;
  logic [SW-1:0] r_lat_size;
  logic [CW-1:0] r_lat_amp;
  logic          r_out_valid;
  sym_t          r_sym;

  logic          w_slot;
  logic          w_in_ready;
  logic          w_accept;
  logic [DW-1:0] w_coef_x;
  logic [DW-1:0] w_diff;
  logic [SW-1:0] w_dc_size;
  logic [CW-1:0] w_dc_amp;
  logic [SW-1:0] w_ac_size;
  logic [CW-1:0] w_ac_amp;
  logic          w_nz;
  logic          w_run_ge16;
  logic          w_pend_nx;
  state_t        w_rest_state;

  assign w_slot     = ~r_out_valid | out_ready;
  assign w_in_ready = (r_state != S_ZRL) & w_slot;
  assign w_accept   = in_valid & w_in_ready;
  assign w_coef_x   = {in_coef[CW-1], in_coef};
  assign w_nz       = |in_coef;
  assign w_run_ge16 = |r_run[IW-1:4];

`ifdef JPEG_RLE_DC_DIFF_EN
  logic [CW-1:0] r_pred;
  logic          r_clr_pend;
  logic          w_clr_now;

  // A clear takes effect only at a block boundary with no ZRL burst still draining.
  assign w_clr_now = (pred_clr | r_clr_pend) & (r_idx == '0) & (r_state != S_ZRL);
  assign w_pend_nx = ~w_clr_now & (pred_clr | r_clr_pend);
  assign w_diff    = w_coef_x - (w_clr_now ? DW'(0) : {r_pred[CW-1], r_pred});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pred     <= '0;
      r_clr_pend <= 1'b0;
    end else begin
      r_clr_pend <= w_pend_nx;
      if (w_clr_now) r_pred <= '0;
      if (w_accept && (r_idx == '0)) r_pred <= in_coef;
    end
  end
`else
  logic w_unused_clr;

  assign w_unused_clr = pred_clr;
  assign w_pend_nx    = 1'b0;
  assign w_diff       = w_coef_x;
`endif

  assign w_rest_state = w_pend_nx ? S_HOLD : S_ACCEPT;
  assign w_dc_size    = f_cat(w_diff);
  assign w_dc_amp     = f_amp(w_diff, w_dc_size);
  assign w_ac_size    = f_cat(w_coef_x);
  assign w_ac_amp     = f_amp(w_coef_x, w_ac_size);

  // Control FSM and registered symbol output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_ACCEPT;
      r_idx       <= '0;
      r_run       <= '0;
      r_lat_size  <= '0;
      r_lat_amp   <= '0;
      r_out_valid <= 1'b0;
      r_sym       <= '0;
    end else begin
      if (r_out_valid && out_ready) r_out_valid <= 1'b0;
      case (r_state)
        S_ACCEPT, S_HOLD: begin
          r_state <= w_rest_state;
          if (w_accept) begin
            r_idx <= r_idx + IW'(1);
            if (r_idx == '0) begin
              r_out_valid <= 1'b1;
              r_sym       <= f_sym('0, w_dc_size, w_dc_amp, 1'b1, 1'b0);
              r_run       <= '0;
            end else if (!w_nz) begin
              if (r_idx == IW'(63)) begin
                r_out_valid <= 1'b1;
                r_sym       <= f_sym('0, '0, '0, 1'b0, 1'b1);
                r_run       <= '0;
              end else begin
                r_run <= r_run + IW'(1);
              end
            end else if (w_run_ge16) begin
              r_out_valid <= 1'b1;
              r_sym       <= f_sym(SW'(15), '0, '0, 1'b0, 1'b0);
              r_run       <= r_run - IW'(16);
              r_lat_size  <= w_ac_size;
              r_lat_amp   <= w_ac_amp;
              r_state     <= S_ZRL;
            end else begin
              r_out_valid <= 1'b1;
              r_sym       <= f_sym(r_run[SW-1:0], w_ac_size, w_ac_amp, 1'b0, 1'b0);
              r_run       <= '0;
            end
          end
        end
        S_ZRL: begin
          if (w_slot) begin
            r_out_valid <= 1'b1;
            if (w_run_ge16) begin
              r_sym <= f_sym(SW'(15), '0, '0, 1'b0, 1'b0);
              r_run <= r_run - IW'(16);
            end else begin
              r_sym   <= f_sym(r_run[SW-1:0], r_lat_size, r_lat_amp, 1'b0, 1'b0);
              r_run   <= '0;
              r_state <= w_rest_state;
            end
          end
        end
        default: r_state <= S_ACCEPT;
      endcase
    end
  end

  assign in_ready  = w_in_ready;
  assign out_valid = r_out_valid;
  assign out_run   = r_sym.run;
  assign out_size  = r_sym.size;
  assign out_amp   = r_sym.amp;
  assign out_dc    = r_sym.dc;
  assign out_eob   = r_sym.eob;

endmodule

// File: doc/jpeg_rle_encoder.md
JPEG_RLE_ENCODER -- requirements
Module: jpeg_rle_encoder

Interface
REQ-001 The block SHALL have ports: clk, input, 1, sole clock; all state updates on its rising edge.
REQ-002 The block SHALL have ports: rst_n, input, 1, asynchronous active-low reset.
REQ-003 The block SHALL have ports: in_valid, input, 1, coefficient present.
REQ-004 The block SHALL have ports: in_ready, output, 1, coefficient accepted when in_valid and in_ready are both high.
REQ-005 The block SHALL have ports: in_coef, input, 12, signed quantized coefficient in zigzag order, 64 per block, index 0 = DC.
REQ-006 The block SHALL have ports: pred_clr, input, 1, zero the DC predictor (restart marker); honoured only between blocks.
REQ-007 The block SHALL have ports: out_valid, output, 1, symbol present.
REQ-008 The block SHALL have ports: out_ready, input, 1, downstream Huffman stage accepts the symbol.
REQ-009 The block SHALL have ports: out_run, output, 4, zero-run length.
REQ-010 The block SHALL have ports: out_size, output, 4, magnitude category 0..12.
REQ-011 The block SHALL have ports: out_amp, output, 12, amplitude bits, right-aligned.
REQ-012 The block SHALL have ports: out_dc, output, 1, symbol is the DC term.
REQ-013 The block SHALL have ports: out_eob, output, 1, symbol is EOB.

Function
REQ-014 The block SHALL keep a 6-bit coefficient index: it increments on each accept, and it wraps from 63 to 0, which starts a new block.
REQ-015 The block SHALL handle index 0 as follows: diff = in_coef - pred with 13-bit signed arithmetic; pred <= in_coef; emit out_dc=1, run=0, size=cat(diff).
REQ-016 The block SHALL compute size as cat(x): 0 if x=0, otherwise bit-length of |x|.
REQ-017 The block SHALL compute amp as the low size bits of x if x>0, and the low size bits of x-1 if x<0; bits above size are 0.
REQ-018 The block SHALL handle a zero AC coefficient at index 1..62 by incrementing the 6-bit run counter and emitting no symbol.
REQ-019 The block SHALL handle a nonzero AC coefficient as follows: while run>=16, emit ZRL (run=15, size=0, amp=0) and subtract 16; then emit (run, cat, amp) and clear run.
REQ-020 The block SHALL handle a zero at index 63 by emitting EOB (run=0, size=0, out_eob=1) and clearing run; pending ZRLs are discarded, never emitted.
REQ-021 The block SHALL handle a nonzero at index 63 by following the ZRL rule with no EOB.
REQ-022 The block SHALL use FSM states ACCEPT, ZRL and HOLD.
REQ-023 In ACCEPT, in_ready SHALL equal (!out_valid | out_ready).
REQ-024 The block SHALL enter ZRL when a nonzero AC coefficient is accepted with run>=16; the coefficient is latched; in_ready=0; one ZRL is emitted per output handshake.
REQ-025 When run<16 in ZRL, the block SHALL emit the latched symbol and return to ACCEPT.
REQ-026 The block SHALL use HOLD only when pred_clr is asserted mid-block; it is recorded and applied when index wraps to 0.
REQ-027 The block SHALL register its outputs; a symbol appears 1 cycle after its accepting edge.
REQ-028 Output fields SHALL remain stable while out_valid=1 and out_ready=0.
REQ-029 The block SHALL never drop a symbol or duplicate one.
REQ-030 When an accept and an output handshake fall in the same cycle, the new symbol SHALL replace the old one with no bubble.
REQ-031 With out_ready held high and no ZRLs, throughput SHALL be 1 coefficient/cycle.

Reset
REQ-032 Asserting rst_n=0 SHALL set the state to ACCEPT, index=0, run=0, pred=0, out_valid=0, and all out_* fields to 0.
REQ-033 After reset, in_ready SHALL be 1.
REQ-034 Reset asserted mid-block SHALL abandon the partial block; the next accepted coefficient is DC.
REQ-035 Deassertion of rst_n SHALL be synchronised externally; the block SHALL not sample inputs on the first edge after deassertion.

Configuration
REQ-036 Macro JPEG_RLE_DC_DIFF_EN SHALL control DC differential prediction.
REQ-037 When JPEG_RLE_DC_DIFF_EN is defined, the block SHALL apply DC differential prediction per REQ-015 and REQ-026.
REQ-038 When JPEG_RLE_DC_DIFF_EN is undefined, the block SHALL set diff = in_coef, remove the pred register, and ignore pred_clr; all AC behaviour is unchanged.

Verification
REQ-039 The bench SHALL cover: with DIFF_EN, block1 DC=+5 then block2 DC=+3 (all AC zero) -> (dc, size 3, amp 101), EOB, then (dc, size 2, amp 01 for -2), EOB.
REQ-040 The bench SHALL cover: AC sequence index1=-1, rest zero -> (run 0, size 1, amp 0), then EOB.
REQ-041 The bench SHALL cover: 20 zeros then AC=+7 -> ZRL (15,0), then (4,3,111); in_ready low for exactly 1 cycle.
REQ-042 The bench SHALL cover: index 63=+1 after 62 zeros -> 3 ZRLs, then (14,1,1), and no EOB.
REQ-043 The bench SHALL cover: out_ready toggling at random -> the symbol stream is identical to the out_ready=1 run, and fields stay stable while stalled.
REQ-044 The bench SHALL cover: rst_n pulsed at index 30 -> outputs cleared, and the next coefficient is treated as DC with pred=0.
